// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-side control path: JumpOP encodings,
// the PC sequencer state enum, default vectors and a saturating increment.
package cpu_pkg;

    typedef enum logic [1:0] {
        JOP_SEQ = 2'b00,
        JOP_BR  = 2'b01,
        JOP_REG = 2'b10,
        JOP_ABS = 2'b11
    } jump_op_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Purely combinational next-PC selection for one instruction, plus the
// branch-taken indication and a misaligned-target flag.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [1:0]      jump_op_i,
    input  logic            zero_i,
    input  logic            branch_ne_i,
    input  logic [15:0]     imm16_i,
    input  logic [25:0]     target26_i,
    input  logic [PC_W-1:0] rs_data_i,
    output logic [PC_W-1:0] pc4_o,
    output logic [PC_W-1:0] next_pc_o,
    output logic            taken_o,
    output logic            misalign_o
);

    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] abs_tgt;

    // Sequential address, branch offset in bytes and absolute jump target.
    always_comb begin
        pc4_o   = pc_i + PC_W'(4);
        br_off  = {{(PC_W-18){imm16_i[15]}}, imm16_i, 2'b00};
        abs_tgt = {pc4_o[PC_W-1:28], target26_i, 2'b00};
    end

    // Select the candidate next PC from the jump code; beq/bne share one path.
    always_comb begin
        taken_o   = 1'b0;
        next_pc_o = pc4_o;
        case (jump_op_e'(jump_op_i))
            JOP_SEQ: next_pc_o = pc4_o;
            JOP_BR: begin
                taken_o   = zero_i ^ branch_ne_i;
                next_pc_o = taken_o ? (pc4_o + br_off) : pc4_o;
            end
            JOP_REG: next_pc_o = rs_data_i;
            JOP_ABS: next_pc_o = abs_tgt;
            default: next_pc_o = pc4_o;
        endcase
    end

    // Only a register jump can actually produce a non-word address.
    always_comb begin
        misalign_o = |next_pc_o[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle CPU: drives the instruction
// memory address with a valid/ready handshake and supplies the link address.
// Optional statistics counters are built when PC_SEQ_STATS_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | first cycle after reset, no fetch request issued
// ST_RUN  | fetch request at PC; PC advances when accepted and not stalled
// ST_HALT | fetching stopped, PC frozen; left only through reset
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR),
    parameter logic [PC_W-1:0] TRAP_VECTOR  = PC_W'(DEF_TRAP_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      jump_op,
    input  logic            zero,
    input  logic            branch_ne,
    input  logic [15:0]     imm16,
    input  logic [25:0]     target26,
    input  logic [PC_W-1:0] rs_data,
    input  logic            stall,
    input  logic            halt,
    input  logic            imem_ready,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_valid,
    output logic [PC_W-1:0] link_addr,
    output logic            misalign,
`ifdef PC_SEQ_STATS_EN
    output logic [31:0]     taken_cnt,
    output logic [31:0]     redirect_cnt,
`endif
    output logic            halted
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] cand_pc;
    logic            br_taken;
    logic            cand_misalign;
    logic            accept;

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_next (
        .pc_i        (pc_q),
        .jump_op_i   (jump_op),
        .zero_i      (zero),
        .branch_ne_i (branch_ne),
        .imm16_i     (imm16),
        .target26_i  (target26),
        .rs_data_i   (rs_data),
        .pc4_o       (pc4),
        .next_pc_o   (cand_pc),
        .taken_o     (br_taken),
        .misalign_o  (cand_misalign)
    );

    // A fetch is consumed only while running, accepted by memory and not stalled.
    always_comb begin
        accept = (state_q == ST_RUN) && imem_ready && !stall;
    end

    // Next state, next PC and trap pulse; halt lets a same-cycle advance land first.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = halt ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    pc_d       = cand_misalign ? TRAP_VECTOR : cand_pc;
                    misalign_d = cand_misalign;
                end
                if (halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC and trap pulse registers; reset also kills a pending pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Fetch interface and status outputs.
    always_comb begin
        imem_addr  = pc_q;
        imem_valid = (state_q == ST_RUN);
        link_addr  = pc4;
        misalign   = misalign_q;
        halted     = (state_q == ST_HALT);
    end

`ifdef PC_SEQ_STATS_EN
    logic [31:0] taken_cnt_q;
    logic [31:0] redirect_cnt_q;
    logic        redirect_ev;

    // Register and absolute jumps always redirect; a trap comes from a register jump.
    always_comb begin
        redirect_ev = accept && ((jump_op_e'(jump_op) == JOP_REG) ||
                                 (jump_op_e'(jump_op) == JOP_ABS) ||
                                 cand_misalign);
    end

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (accept && br_taken) begin
                taken_cnt_q <= sat_inc32(taken_cnt_q);
            end
            if (redirect_ev) begin
                redirect_cnt_q <= sat_inc32(redirect_cnt_q);
            end
        end
    end

    assign taken_cnt    = taken_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = br_taken;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  jump_op = 2'b00;
    logic        zero = 1'b0;
    logic        branch_ne = 1'b0;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] target26 = 26'h0;
    logic [31:0] rs_data = 32'h0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] link_addr;
    logic        misalign;
    logic        halted;
`ifdef PC_SEQ_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] redirect_cnt;
`endif

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .jump_op      (jump_op),
        .zero         (zero),
        .branch_ne    (branch_ne),
        .imm16        (imm16),
        .target26     (target26),
        .rs_data      (rs_data),
        .stall        (stall),
        .halt         (halt),
        .imem_ready   (imem_ready),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .link_addr    (link_addr),
        .misalign     (misalign),
`ifdef PC_SEQ_STATS_EN
        .taken_cnt    (taken_cnt),
        .redirect_cnt (redirect_cnt),
`endif
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: 0 = boot, 1 = running, 2 = halted.
    logic [31:0] m_pc    = 32'h0;
    int          m_st    = 0;
    bit          m_mis   = 1'b0;
    longint      m_taken = 0;
    longint      m_redir = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_valid", 32'(imem_valid), 32'(m_st == 1));
        chk("link_addr", link_addr, m_pc + 32'd4);
        chk("misalign", 32'(misalign), 32'(m_mis));
        chk("halted", 32'(halted), 32'(m_st == 2));
`ifdef PC_SEQ_STATS_EN
        chk("taken_cnt", taken_cnt, 32'(m_taken));
        chk("redirect_cnt", redirect_cnt, 32'(m_redir));
`endif
    end

    task automatic model_reset();
        m_pc    = 32'h0;
        m_st    = 0;
        m_mis   = 1'b0;
        m_taken = 0;
        m_redir = 0;
    endtask

    // One clock: work out the model's next view from the current inputs.
    task automatic cyc();
        logic [31:0] npc, pc4, tgt;
        int          nst;
        bit          nmis;
        longint      ntk, nrd;
        int          off;
        bit          tk;
        npc  = m_pc;
        nst  = m_st;
        nmis = 1'b0;
        ntk  = m_taken;
        nrd  = m_redir;
        if (m_st == 0) begin
            nst = halt ? 2 : 1;
        end else if (m_st == 1) begin
            if (imem_ready && !stall) begin
                pc4 = m_pc + 32'd4;
                tk  = 1'b0;
                case (jump_op)
                    2'd0: tgt = pc4;
                    2'd1: begin
                        tk  = (zero != branch_ne);
                        off = $signed(imm16) * 4;
                        tgt = tk ? pc4 + 32'(off) : pc4;
                    end
                    2'd2: tgt = rs_data;
                    default: tgt = (pc4 & 32'hF000_0000) | (32'(target26) * 32'd4);
                endcase
                if (tgt % 4 != 0) begin
                    npc  = 32'h80;
                    nmis = 1'b1;
                end else begin
                    npc = tgt;
                end
                if (tk && ntk < 64'hFFFF_FFFF) ntk++;
                if (jump_op >= 2'd2 && nrd < 64'hFFFF_FFFF) nrd++;
            end
            if (halt) nst = 2;
        end
        @(posedge clk);
        #1;
        m_pc    = npc;
        m_st    = nst;
        m_mis   = nmis;
        m_taken = ntk;
        m_redir = nrd;
    endtask

    task automatic jump_reg(input logic [31:0] addr);
        jump_op = 2'd2;
        rs_data = addr;
        cyc();
        jump_op = 2'd0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // 1: boot, then sequential fetch; stall has no effect while booting
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("lit_boot_valid", 32'(imem_valid), 32'd0);
        stall = 1'b1;
        cyc();
        stall = 1'b0;
        chk("lit_run_addr0", imem_addr, 32'h0);
        chk("lit_run_valid", 32'(imem_valid), 32'd1);
        cyc();
        chk("lit_addr4", imem_addr, 32'h4);
        cyc();
        chk("lit_addr8", imem_addr, 32'h8);
        chk("lit_link8", link_addr, 32'hC);

        // 2: beq / bne with a backward offset of two words
        jump_reg(32'h100);
        chk("lit_addr100", imem_addr, 32'h100);
        jump_op = 2'd1; branch_ne = 1'b0; zero = 1'b1; imm16 = 16'hFFFE;
        cyc();
        chk("lit_beq_taken", imem_addr, 32'hFC);
        jump_reg(32'h100);
        jump_op = 2'd1; zero = 1'b0;
        cyc();
        chk("lit_beq_not", imem_addr, 32'h104);
        jump_reg(32'h100);
        jump_op = 2'd1; branch_ne = 1'b1; zero = 1'b0;
        cyc();
        chk("lit_bne_taken", imem_addr, 32'hFC);
        jump_op = 2'd1; zero = 1'b1; imm16 = 16'h0010;
        cyc();
        chk("lit_bne_not", imem_addr, 32'h100);
        branch_ne = 1'b0; imm16 = 16'h0010;
        jump_op = 2'd1;
        cyc();
        chk("lit_beq_fwd", imem_addr, 32'h144);
        jump_op = 2'd0;

        // 3: absolute and register jumps
        jump_reg(32'h4000_0010);
        jump_op = 2'd3; target26 = 26'h10;
        cyc();
        chk("lit_abs", imem_addr, 32'h4000_0040);
        jump_reg(32'h200);
        chk("lit_jr", imem_addr, 32'h200);

        // 4: misaligned register target traps with a one-cycle pulse
        jump_reg(32'h203);
        chk("lit_trap_addr", imem_addr, 32'h80);
        chk("lit_trap_pulse", 32'(misalign), 32'd1);
        cyc();
        chk("lit_pulse_gone", 32'(misalign), 32'd0);
        chk("lit_after_trap", imem_addr, 32'h84);

        // 4b: reset wipes out a pending misalign pulse
        jump_reg(32'h2);
        async_reset();
        chk("lit_rst_pulse", 32'(misalign), 32'd0);
        release_reset();
        cyc();

        // wrap of PC+4 at the top of the address space
        jump_reg(32'hFFFF_FFFC);
        chk("lit_link_wrap", link_addr, 32'h0);
        cyc();
        chk("lit_pc_wrap", imem_addr, 32'h0);

        // 5: memory not ready, then stalled, then released
        jump_reg(32'h20);
        imem_ready = 1'b0;
        repeat (3) cyc();
        chk("lit_notready_hold", imem_addr, 32'h20);
        imem_ready = 1'b1;
        stall = 1'b1;
        jump_op = 2'd3;
        repeat (2) cyc();
        chk("lit_stall_hold", imem_addr, 32'h20);
        stall = 1'b0;
        jump_op = 2'd0;
        cyc();
        chk("lit_resume", imem_addr, 32'h24);

        // halt while stalled keeps PC
        stall = 1'b1;
        halt  = 1'b1;
        cyc();
        stall = 1'b0;
        halt  = 1'b0;
        chk("lit_halt_stall_pc", imem_addr, 32'h24);
        chk("lit_halt_stall", 32'(halted), 32'd1);
        async_reset();
        release_reset();
        cyc();

        // 6: halt together with an accepted fetch, then reset while halted
        jump_reg(32'h30);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        chk("lit_halt_pc", imem_addr, 32'h34);
        chk("lit_halted", 32'(halted), 32'd1);
        chk("lit_halt_valid", 32'(imem_valid), 32'd0);
        jump_op = 2'd2; rs_data = 32'h500; stall = 1'b1;
        repeat (3) cyc();
        stall = 1'b0; jump_op = 2'd0;
        chk("lit_halt_frozen", imem_addr, 32'h34);
        async_reset();
        chk("lit_rst_addr", imem_addr, 32'h0);
        chk("lit_rst_halted", 32'(halted), 32'd0);
        release_reset();
        cyc();
        cyc();
        chk("lit_rerun", imem_addr, 32'h4);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer of the 2-bit JumpOP code from the jump-control decoder; owns the program counter.
- Each accepted fetch it computes next PC:
  - sequential
  - conditional branch (resolved with ALU Zero)
  - register-indirect
  - absolute jump
- Drives the instruction-memory address with a valid/ready handshake.
- Supplies the link address for jal/jalr.
- Sits between the decode/ALU stage and the instruction memory of the single-cycle CPU.

Parameters:
- PC_W, 32, program counter width in bits.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0080, redirect target on a misaligned jump/branch target.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- jump_op  input  2  00 sequential, 01 branch, 10 register jump (jr/jalr), 11 absolute jump (j/jal).
- zero  input  1  ALU Zero flag for the current instruction.
- branch_ne  input  1  1 = bne (taken when zero=0); 0 = beq (taken when zero=1).
- imm16  input  16  branch offset in words, sign-extended.
- target26  input  26  absolute jump index.
- rs_data  input  PC_W  register value for jr/jalr.
- stall  input  1  hold PC; no advance this cycle.
- halt  input  1  enter HALT state.
- imem_ready  input  1  instruction memory accepts the address this cycle.
- imem_addr  output  PC_W  current PC.
- imem_valid  output  1  imem_addr is a fetch request.
- link_addr  output  PC_W  PC+4 of the current instruction.
- misalign  output  1  one-cycle pulse; the last redirect was trapped.
- halted  output  1  FSM is in HALT.

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_VECTOR; state=BOOT.
  - imem_valid=0, misalign=0, halted=0; link_addr=RESET_VECTOR+4.
- States:
  - BOOT: one cycle with imem_valid=0, then RUN.
  - RUN: imem_valid=1.
  - HALT: imem_valid=0, halted=1, PC frozen. Exits only by reset.
- Advance rule: PC updates on a rising edge only when state=RUN && imem_valid && imem_ready && !stall. Otherwise PC holds and jump_op is ignored.
- Next-PC computation (pc4 = PC+4, modulo 2^PC_W, wraps silently):
  - 00: pc4.
  - 01: if taken (zero XOR branch_ne), pc4 + (sext(imm16)<<2); else pc4.
  - 10: rs_data.
  - 11: {pc4[31:28], target26, 2'b00}.
- Misaligned target: if the candidate next PC[1:0] != 0 (reachable only via code 10), PC=TRAP_VECTOR and misalign pulses high for exactly the following cycle.
- link_addr: combinational pc4 of the current PC, valid whenever imem_valid=1.
- halt vs. advance in the same cycle: the advance completes first, then state goes to HALT.
- halt while stalled: goes to HALT with PC held.
- stall has no effect in BOOT or HALT.
- Reset asserted mid-operation overrides everything, including a pending misalign pulse.
- Latency: the new PC appears on imem_addr the cycle after the accepting edge.

Optional Feature:
- Macro: PC_SEQ_STATS_EN.
- Defined:
  - Adds two 32-bit saturating counters, taken_cnt and redirect_cnt, plus output ports of the same names.
  - taken_cnt increments on each accepted taken branch.
  - redirect_cnt increments on each accepted code 10/11 or trap.
  - Both counters reset to 0.
- Undefined: the counters and ports are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - JumpOP encodings JOP_SEQ=2'b00, JOP_BR=2'b01, JOP_REG=2'b10, JOP_ABS=2'b11.
  - FSM state enum (BOOT, RUN, HALT).
  - Default vector constants.
- One natural sub-module: pc_next_calc, a purely combinational next-PC plus misalign computation. pc_sequencer holds the register, FSM and counters.

Test Plan:
1. Reset release, imem_ready=1, jump_op=00 -> cycle 1 imem_valid=0. Then imem_addr sequence 0x0, 0x4, 0x8; link_addr = addr+4.
2. PC=0x100, jump_op=01, branch_ne=0, zero=1, imm16=16'hFFFE -> next PC 0xFC. Same with zero=0 -> 0x104. branch_ne=1, zero=0 -> 0xFC.
3. PC=0x4000_0010, jump_op=11, target26=26'h10 -> next PC 0x4000_0040. jump_op=10, rs_data=0x200 -> 0x200.
4. jump_op=10, rs_data=0x203 -> PC=0x80 and misalign high for exactly one cycle; redirect_cnt+1 when the macro is defined.
5. PC=0x20, imem_ready=0 for 3 cycles, then stall=1 for 2 cycles -> PC stays 0x20 throughout. Advances to 0x24 when both clear.
6. halt=1 with an accepted fetch at 0x30 -> PC=0x34, halted=1, imem_valid=0. rst low mid-HALT -> PC=0x0, halted=0 immediately (async).
